// File: rtl/mem_block_mover.sv
// Block-copy DMA engine owning the single data-memory port: copies len words src->dst, 2 cycles/word.
// Optional MOVER_FILL_EN adds a pattern-fill mode (fill/pattern ports, 1 cycle/word).
module mem_block_mover #(
   parameter int AW = 16,
   parameter int DW = 16,
   parameter int LW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [LW-1:0] len,
`ifdef MOVER_FILL_EN
   input  logic          fill,
   input  logic [DW-1:0] pattern,
`endif
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          mem_we
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [LW-1:0] ONE_L = {{(LW-1){1'b0}}, 1'b1};

   state_t        state_r;
   logic [AW-1:0] sp_r;
   logic [AW-1:0] dp_r;
   logic [LW-1:0] cnt_r;
   logic          fill_r;

`ifndef MOVER_FILL_EN
   assign fill_r = 1'b0;
`endif

   // Transfer FSM; all memory-port and status outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= S_IDLE;
         sp_r      <= '0;
         dp_r      <= '0;
         cnt_r     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
`ifdef MOVER_FILL_EN
         fill_r    <= 1'b0;
`endif
      end else begin
         case (state_r)
            S_IDLE: begin
               done   <= 1'b0;
               mem_we <= 1'b0;
               if (start) begin
                  sp_r  <= src;
                  dp_r  <= dst;
                  cnt_r <= len;
                  busy  <= 1'b1;
`ifdef MOVER_FILL_EN
                  fill_r <= fill;
`endif
                  if (len == '0) begin
                     state_r <= S_DONE;
                     done    <= 1'b1;
                  end
`ifdef MOVER_FILL_EN
                  else if (fill) begin
                     state_r   <= S_WRITE;
                     mem_addr  <= dst;
                     mem_wdata <= pattern;
                     mem_we    <= 1'b1;
                  end
`endif
                  else begin
                     state_r  <= S_READ;
                     mem_addr <= src;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            S_READ: begin
               mem_wdata <= mem_rdata;
               mem_addr  <= dp_r;
               mem_we    <= 1'b1;
               sp_r      <= sp_r + ONE_A;
               state_r   <= S_WRITE;
            end
            S_WRITE: begin
               // The memory commits mem_wdata at dp on this edge.
               dp_r  <= dp_r + ONE_A;
               cnt_r <= cnt_r - ONE_L;
               if (cnt_r == ONE_L) begin
                  mem_we  <= 1'b0;
                  done    <= 1'b1;
                  state_r <= S_DONE;
               end else if (fill_r) begin
                  mem_addr <= dp_r + ONE_A;
                  mem_we   <= 1'b1;
               end else begin
                  mem_we   <= 1'b0;
                  mem_addr <= sp_r;
                  state_r  <= S_READ;
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed self-checking bench for mem_block_mover (AW=8 build) with a behavioural memory.
// Fill-mode steps are compiled only when MOVER_FILL_EN is defined.
module tb_mem_block_mover;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [LW-1:0] len;
`ifdef MOVER_FILL_EN
   logic          fill;
   logic [DW-1:0] pattern;
`endif
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_we;

   logic [DW-1:0] mem [0:(2**AW)-1];
   logic          tb_we;
   logic [AW-1:0] tb_addr;
   logic [DW-1:0] tb_data;

   int n_checks = 0;
   int n_fail   = 0;
   int we_cnt   = 0;
   int done_cnt = 0;
   int cyc;
   int base;

   mem_block_mover #(.AW(AW), .DW(DW), .LW(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src       (src),
      .dst       (dst),
      .len       (len),
`ifdef MOVER_FILL_EN
      .fill      (fill),
      .pattern   (pattern),
`endif
      .busy      (busy),
      .done      (done),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_we    (mem_we)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt        <= we_cnt + 1;
      end else if (tb_we) begin
         mem[tb_addr] <= tb_data;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return {8'h5A, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
      tb_addr = a;
      tb_data = d;
      tb_we   = 1'b1;
      tick();
      tb_we   = 1'b0;
   endtask

   task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
      src   = s;
      dst   = d;
      len   = l;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int c0, input int bound, output int c);
      c = c0;
      while (!done && c < bound) begin
         tick();
         c++;
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'bx;
      src   = 'x;
      dst   = 'x;
      len   = 'x;
`ifdef MOVER_FILL_EN
      fill    = 1'bx;
      pattern = 'x;
`endif
      tb_we   = 1'b0;
      tb_addr = '0;
      tb_data = '0;
      #12;
      check("rst_busy",  busy,      32'd0);
      check("rst_done",  done,      32'd0);
      check("rst_we",    mem_we,    32'd0);
      check("rst_addr",  mem_addr,  32'd0);
      check("rst_wdata", mem_wdata, 32'd0);

      start = 1'b0; src = '0; dst = '0; len = '0;
`ifdef MOVER_FILL_EN
      fill = 1'b0; pattern = '0;
`endif
      tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("idle_busy", busy,   32'd0);
      check("idle_we",   we_cnt, 32'd0);

      for (int a = 0; a < 2**AW; a++) poke(a[AW-1:0], init_val(a[AW-1:0]));
      poke(8'd10, 16'hAAAA);
      poke(8'd11, 16'hBBBB);
      poke(8'd12, 16'hCCCC);
      poke(8'd13, 16'hDDDD);
      poke(8'd20, 16'd7);

      // 4-word copy with a stray start mid-transfer and a start in the DONE cycle
      base = we_cnt;
      go(8'd10, 8'd40, 8'd4);
      check("cp_rd0_addr", mem_addr, 32'd10);
      check("cp_rd0_we",   mem_we,   32'd0);
      check("cp_rd0_busy", busy,     32'd1);
      tick();
      check("cp_wr0_we",    mem_we,    32'd1);
      check("cp_wr0_addr",  mem_addr,  32'd40);
      check("cp_wr0_wdata", mem_wdata, 32'hAAAA);
      src = 8'd100; dst = 8'd200; len = 8'd1; start = 1'b1;
      tick();
      start = 1'b0;
      check("ign_start_addr", mem_addr, 32'd11);
      check("ign_start_we",   mem_we,   32'd0);
      wait_done(3, 30, cyc);
      check("cp_done_cycle", cyc,  32'd9);
      check("cp_done_busy",  busy, 32'd1);
      src = 8'd10; dst = 8'd80; len = 8'd2; start = 1'b1;
      tick();
      start = 1'b0;
      check("done_start_busy", busy, 32'd0);
      check("done_start_done", done, 32'd0);
      tick();
      check("done_start_idle", busy, 32'd0);
      check("cp_m40", mem[40], 32'hAAAA);
      check("cp_m41", mem[41], 32'hBBBB);
      check("cp_m42", mem[42], 32'hCCCC);
      check("cp_m43", mem[43], 32'hDDDD);
      check("cp_src13", mem[13], 32'hDDDD);
      check("cp_m200", mem[200], init_val(8'd200));
      check("cp_m80",  mem[80],  init_val(8'd80));
      check("cp_we_pulses", we_cnt - base, 32'd4);

      // zero length
      base = we_cnt;
      go(8'd0, 8'd0, 8'd0);
      check("z_done", done,   32'd1);
      check("z_busy", busy,   32'd1);
      check("z_we",   mem_we, 32'd0);
      tick();
      check("z_done_off", done, 32'd0);
      check("z_busy_off", busy, 32'd0);
      check("z_no_write", we_cnt - base, 32'd0);

      // source address wrap 254,255,0
      go(8'd254, 8'd100, 8'd3);
      wait_done(1, 30, cyc);
      check("wrap_done_cycle", cyc, 32'd7);
      tick();
      check("wrap_m100", mem[100], init_val(8'd254));
      check("wrap_m101", mem[101], init_val(8'd255));
      check("wrap_m102", mem[102], init_val(8'd0));

      // overlapping ascending copy re-reads overwritten words
      go(8'd20, 8'd21, 8'd3);
      wait_done(1, 30, cyc);
      tick();
      check("ovl_m21", mem[21], 32'd7);
      check("ovl_m22", mem[22], 32'd7);
      check("ovl_m23", mem[23], 32'd7);

      // reset during the second WRITE
      base = done_cnt;
      go(8'd10, 8'd60, 8'd4);
      tick();
      tick();
      tick();
      check("rm_wr1_we", mem_we, 32'd1);
      reset = 1'b0;
      #1;
      check("rm_we_drop", mem_we,   32'd0);
      check("rm_busy",    busy,     32'd0);
      check("rm_addr",    mem_addr, 32'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("rm_m60", mem[60], 32'hAAAA);
      check("rm_m61", mem[61], init_val(8'd61));
      check("rm_no_done", done_cnt - base, 32'd0);
      go(8'd10, 8'd60, 8'd4);
      wait_done(1, 30, cyc);
      check("rm_again_cycle", cyc, 32'd9);
      tick();
      check("rm_again_m61", mem[61], 32'hBBBB);
      check("rm_again_m63", mem[63], 32'hDDDD);

`ifdef MOVER_FILL_EN
      fill = 1'b1;
      pattern = 16'hBEEF;
      go(8'd0, 8'd5, 8'd3);
      check("fill_we0",   mem_we,   32'd1);
      check("fill_addr0", mem_addr, 32'd5);
      tick();
      check("fill_we1",   mem_we,   32'd1);
      check("fill_addr1", mem_addr, 32'd6);
      tick();
      check("fill_we2",   mem_we,   32'd1);
      check("fill_addr2", mem_addr, 32'd7);
      tick();
      check("fill_done",  done,     32'd1);
      check("fill_we_off", mem_we,  32'd0);
      tick();
      fill = 1'b0;
      check("fill_m5", mem[5], 32'hBEEF);
      check("fill_m6", mem[6], 32'hBEEF);
      check("fill_m7", mem[7], 32'hBEEF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
